direction_square_pipe: RTL and testbench
========================================

Name: direction_square_pipe

Overview:
Parametrised, elastic successor to the single-cycle direction squarer. It accepts a fixed-point ray direction (x, y, z) under a valid/ready handshake and returns the following after a configurable pipeline latency:
- the three components, passed through;
- their truncated fixed-point squares;
- the squared length |D|^2;
- per-component overflow flags.

It sits between ray generation and the intersection/normalisation units, and supports backpressure, optional saturation and a pass-through tag.

Parameters:
WIDTH, `WIDTH, fixed-point word width of components and squares
Q_BITS, `Q_BITS, fractional bits of the fixed-point format
STAGES, 2, pipeline depth in register stages; legal 1..4, elaboration error otherwise
TAG_W, 8, width of the opaque tag carried alongside each beat

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat this cycle
in_x, in_y, in_z  in  WIDTH each  signed direction components
in_tag  in  TAG_W  opaque tag
in_sat_en  in  1  per-beat mode: 1 = saturate on overflow, 0 = wrap (legacy truncation)
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_x, out_y, out_z  out  WIDTH each  components passed through unchanged
out_sqr_x, out_sqr_y, out_sqr_z  out  WIDTH each  squares, bits [WIDTH+Q_BITS-1:Q_BITS] of the 2*WIDTH product, or saturated
out_len_sqr  out  WIDTH+2  exact sum of the three out_sqr values, unsigned
out_ovf  out  3  per-component overflow flags {z, y, x}
out_tag  out  TAG_W  tag of the beat

Behaviour:
- Reset (rst_n low, asynchronous):
  - all stage valid bits clear;
  - out_valid = 0 and every out_* data field = 0;
  - in_ready = 1 one cycle after rst_n deasserts (combinational from empty pipe).
- Transfers:
  - Input beat transfers on a clk edge with in_valid & in_ready.
  - Output beat transfers on a clk edge with out_valid & out_ready.
- Pipeline advance:
  - STAGES registers, each with its own valid bit.
  - Stage i loads when it is empty, or when stage i+1 takes its beat (last stage: out_ready).
  - in_ready = !valid[0] | adv[0], combinational. Bubbles collapse.
- Timing:
  - Latency is STAGES cycles from input handshake to out_valid with no stall.
  - Throughput is 1 beat/cycle while out_ready = 1.
- Ordering and stalls:
  - Beats are never dropped, duplicated or reordered.
  - While out_valid & !out_ready, all out_* fields hold stable.
- Square arithmetic:
  - Full signed product p = c*c (2*WIDTH bits).
  - Slice s = p[WIDTH+Q_BITS-1:Q_BITS].
  - ovf = |p[2*WIDTH-1:WIDTH+Q_BITS-1]|, i.e. result not representable as a positive WIDTH-bit value.
- Overflow handling:
  - If ovf and the beat's sat_en = 1: square = {1'b0, {WIDTH-1{1'b1}}}.
  - If ovf and sat_en = 0: square = s (wraps, bit-identical to the legacy block).
  - The ovf flag is reported in both modes.
- len_sqr:
  - Zero-extended sum of the three final squares (post-saturation/wrap) in WIDTH+2 bits; never overflows.
- Stage placement:
  - The multiply is in stage 0.
  - Slice, saturation and ovf are in stage min(1, STAGES-1).
  - The len_sqr sum is in the last stage.
  - With STAGES = 1 everything is in one stage.
- sat_en and tag are captured with the beat and travel with it; changing in_sat_en affects only subsequent beats.
- Output masking: whenever out_valid = 0, all out_* data fields read 0, for consumers that do not qualify data.
- Reset mid-operation: in-flight beats are discarded, outputs go to 0 immediately, and there is no partial beat after release.
- Simultaneous input and output handshake on a full pipe: both occur in the same cycle, with no bubble.

Decomposition:
- The shared Types.sv package gets:
  - typedef dsq_beat_t: x, y, z, sqr_x/y/z, ovf[2:0], sat_en, tag; widths from WIDTH/Q_BITS macros;
  - a localparam helper for the saturation max value.
- Sub-module sq_lane (WIDTH, Q_BITS): combinational square, slice, overflow and saturation for one component; instantiated 3x.
- The top level owns the valid/ready chain and stage registers.

Test Plan:
WIDTH=32, Q_BITS=16, STAGES=2.
- Basic: x=1.0 (0x00010000), y=2.0 (0x00020000), z=-3.0 (0xFFFD0000), sat_en=1, out_ready=1 -> 2 cycles later out_sqr = 0x00010000 / 0x00040000 / 0x00090000, out_len_sqr = 0x000E0000, ovf = 0, tag echoed.
- Overflow: x=256.0 (0x01000000), y=z=0:
  - sat_en=1 -> sqr_x = 0x7FFFFFFF, ovf = 3'b001, len_sqr = 0x07FFFFFFF;
  - sat_en=0 -> sqr_x = 0x00000000, ovf = 3'b001.
- Backpressure: 8 back-to-back beats tagged 0..7, out_ready toggling 1,0,0,1,... -> exactly 8 output beats, tags 0..7 in order, outputs stable during every stall, in_ready low once pipe full and stalled.
- Throughput: 16 beats with out_ready=1 -> 16 consecutive out_valid cycles starting cycle 2, in_ready held 1.
- Reset mid-stream: assert rst_n low with 2 beats in flight -> out_valid=0 and all outputs 0 asynchronously; after release no stale beat appears, next input produces normal result.
- STAGES=1 and STAGES=4 rebuild of the basic test -> latency 1 and 4 respectively, same values.

Source files
------------

// File: rtl/direction_square_pipe_pkg.sv
// rtl/direction_square_pipe_pkg.sv - shared widths, beat type and saturation constant
package direction_square_pipe_pkg;

   localparam int DSQ_WIDTH  = 32;
   localparam int DSQ_Q_BITS = 16;
   localparam int DSQ_TAG_W  = 8;

   // Largest positive value a square may take once clamped.
   localparam logic [DSQ_WIDTH-1:0] DSQ_SAT_MAX = {1'b0, {(DSQ_WIDTH-1){1'b1}}};

   typedef struct packed {
      logic [DSQ_WIDTH-1:0] x;
      logic [DSQ_WIDTH-1:0] y;
      logic [DSQ_WIDTH-1:0] z;
      logic [DSQ_WIDTH-1:0] sqr_x;
      logic [DSQ_WIDTH-1:0] sqr_y;
      logic [DSQ_WIDTH-1:0] sqr_z;
      logic [2:0]           ovf;
      logic                 sat_en;
      logic [DSQ_TAG_W-1:0] tag;
   } dsq_beat_t;

endpackage

// File: rtl/direction_square_pipe_if.sv
// rtl/direction_square_pipe_if.sv - input/output beat handshake bundle of the direction squarer
interface direction_square_pipe_if
   import direction_square_pipe_pkg::*;
#(
   parameter int WIDTH = DSQ_WIDTH,
   parameter int TAG_W = DSQ_TAG_W
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_x;
   logic [WIDTH-1:0] in_y;
   logic [WIDTH-1:0] in_z;
   logic [TAG_W-1:0] in_tag;
   logic             in_sat_en;

   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_x;
   logic [WIDTH-1:0] out_y;
   logic [WIDTH-1:0] out_z;
   logic [WIDTH-1:0] out_sqr_x;
   logic [WIDTH-1:0] out_sqr_y;
   logic [WIDTH-1:0] out_sqr_z;
   logic [WIDTH+1:0] out_len_sqr;
   logic [2:0]       out_ovf;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_x, in_y, in_z, in_tag, in_sat_en, out_ready,
      input  in_ready, out_valid, out_x, out_y, out_z,
             out_sqr_x, out_sqr_y, out_sqr_z, out_len_sqr, out_ovf, out_tag
   );

   modport slave (
      input  in_valid, in_x, in_y, in_z, in_tag, in_sat_en, out_ready,
      output in_ready, out_valid, out_x, out_y, out_z,
             out_sqr_x, out_sqr_y, out_sqr_z, out_len_sqr, out_ovf, out_tag
   );
endinterface

// File: rtl/direction_square_pipe_sq_lane.sv
// rtl/direction_square_pipe_sq_lane.sv - one component: square, then slice/overflow/saturate
module sq_lane
   import direction_square_pipe_pkg::*;
#(
   parameter int WIDTH  = DSQ_WIDTH,
   parameter int Q_BITS = DSQ_Q_BITS
) (
   input  logic [WIDTH-1:0]          c,
   output logic [2*WIDTH-Q_BITS-1:0] prod,
   input  logic [2*WIDTH-Q_BITS-1:0] prod_in,
   input  logic                      sat_en,
   output logic [WIDTH-1:0]          sqr,
   output logic                      ovf
);
   localparam int PW = 2*WIDTH - Q_BITS;
   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};

   logic signed [2*WIDTH-1:0] c_ext;

   // The fractional bits below Q_BITS never reach a result, so the product
   // is kept pre-shifted; prod_in may come from a register one stage later.
   assign c_ext = {{WIDTH{c[WIDTH-1]}}, c};
   assign prod  = PW'((c_ext * c_ext) >> Q_BITS);

   assign ovf = |prod_in[PW-1:WIDTH-1];
   assign sqr = (ovf && sat_en) ? SAT_MAX : prod_in[WIDTH-1:0];

endmodule

// File: rtl/direction_square_pipe.sv
// rtl/direction_square_pipe.sv - elastic STAGES-deep pipeline squaring a fixed-point direction
module direction_square_pipe
   import direction_square_pipe_pkg::*;
#(
   parameter int WIDTH  = DSQ_WIDTH,
   parameter int Q_BITS = DSQ_Q_BITS,
   parameter int STAGES = 2,
   parameter int TAG_W  = DSQ_TAG_W
) (
   input logic                    clk,
   input logic                    rst_n,
   direction_square_pipe_if.slave bus
);
   localparam int PW       = 2*WIDTH - Q_BITS;
   localparam int LANE_STG = (STAGES > 1) ? 1 : 0;
   localparam int LAST     = STAGES - 1;

   generate
      if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
         $error("direction_square_pipe: STAGES must be in 1..4");
      end
   endgenerate

   typedef struct packed {
      logic [WIDTH-1:0] x;
      logic [WIDTH-1:0] y;
      logic [WIDTH-1:0] z;
      logic [PW-1:0]    px;
      logic [PW-1:0]    py;
      logic [PW-1:0]    pz;
      logic [WIDTH-1:0] sx;
      logic [WIDTH-1:0] sy;
      logic [WIDTH-1:0] sz;
      logic [2:0]       ovf;
      logic             sat_en;
      logic [TAG_W-1:0] tag;
      logic [WIDTH+1:0] len;
   } beat_t;

   beat_t             stg_q [STAGES];
   beat_t             stg_d [STAGES];
   beat_t             src   [STAGES];
   beat_t             in_beat;
   beat_t             b;
   logic [STAGES-1:0] vld_q;
   logic [STAGES-1:0] vld_d;
   logic [STAGES-1:0] vld_src;
   logic [STAGES-1:0] load;
   logic              nxt;

   logic [PW-1:0]     prod_x, prod_y, prod_z;
   logic [PW-1:0]     pin_x, pin_y, pin_z;
   logic [WIDTH-1:0]  sqr_x, sqr_y, sqr_z;
   logic              ovf_x, ovf_y, ovf_z;

   always_comb begin
      in_beat        = '0;
      in_beat.x      = bus.in_x;
      in_beat.y      = bus.in_y;
      in_beat.z      = bus.in_z;
      in_beat.sat_en = bus.in_sat_en;
      in_beat.tag    = bus.in_tag;
   end

   assign src[0]     = in_beat;
   assign vld_src[0] = bus.in_valid;
   generate
      for (genvar g = 1; g < STAGES; g++) begin : g_src
         assign src[g]     = stg_q[g-1];
         assign vld_src[g] = vld_q[g-1];
      end
      // With one stage the slice works on the same-cycle product.
      if (LANE_STG == 0) begin : g_pin_comb
         assign pin_x = prod_x;
         assign pin_y = prod_y;
         assign pin_z = prod_z;
      end else begin : g_pin_reg
         assign pin_x = src[LANE_STG].px;
         assign pin_y = src[LANE_STG].py;
         assign pin_z = src[LANE_STG].pz;
      end
   endgenerate

   sq_lane #(.WIDTH(WIDTH), .Q_BITS(Q_BITS)) u_lane_x (
      .c(bus.in_x), .prod(prod_x), .prod_in(pin_x),
      .sat_en(src[LANE_STG].sat_en), .sqr(sqr_x), .ovf(ovf_x)
   );
   sq_lane #(.WIDTH(WIDTH), .Q_BITS(Q_BITS)) u_lane_y (
      .c(bus.in_y), .prod(prod_y), .prod_in(pin_y),
      .sat_en(src[LANE_STG].sat_en), .sqr(sqr_y), .ovf(ovf_y)
   );
   sq_lane #(.WIDTH(WIDTH), .Q_BITS(Q_BITS)) u_lane_z (
      .c(bus.in_z), .prod(prod_z), .prod_in(pin_z),
      .sat_en(src[LANE_STG].sat_en), .sqr(sqr_z), .ovf(ovf_z)
   );

   always_comb begin
      nxt   = bus.out_ready;
      load  = '0;
      vld_d = vld_q;
      b     = '0;
      for (int i = 0; i < STAGES; i++) begin
         stg_d[i] = stg_q[i];
      end
      // A stage may load when empty or when its beat leaves downstream.
      for (int i = STAGES - 1; i >= 0; i--) begin
         load[i] = !vld_q[i] || nxt;
         nxt     = load[i];
      end
      for (int i = 0; i < STAGES; i++) begin
         b = src[i];
         if (i == 0) begin
            b.px = prod_x;
            b.py = prod_y;
            b.pz = prod_z;
         end
         if (i == LANE_STG) begin
            b.sx  = sqr_x;
            b.sy  = sqr_y;
            b.sz  = sqr_z;
            b.ovf = {ovf_z, ovf_y, ovf_x};
         end
         if (i == LAST) begin
            b.len = {2'b00, b.sx} + {2'b00, b.sy} + {2'b00, b.sz};
         end
         // Empty stages carry zeros so the outputs read 0 without a beat.
         if (load[i]) begin
            vld_d[i] = vld_src[i];
            stg_d[i] = vld_src[i] ? b : '0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < STAGES; i++) begin
            stg_q[i] <= '0;
         end
      end else begin
         vld_q <= vld_d;
         for (int i = 0; i < STAGES; i++) begin
            stg_q[i] <= stg_d[i];
         end
      end
   end

   assign bus.in_ready    = load[0];
   assign bus.out_valid   = vld_q[LAST];
   assign bus.out_x       = stg_q[LAST].x;
   assign bus.out_y       = stg_q[LAST].y;
   assign bus.out_z       = stg_q[LAST].z;
   assign bus.out_sqr_x   = stg_q[LAST].sx;
   assign bus.out_sqr_y   = stg_q[LAST].sy;
   assign bus.out_sqr_z   = stg_q[LAST].sz;
   assign bus.out_len_sqr = stg_q[LAST].len;
   assign bus.out_ovf     = stg_q[LAST].ovf;
   assign bus.out_tag     = stg_q[LAST].tag;

endmodule

// File: tb/tb_direction_square_pipe.sv
// tb/tb_direction_square_pipe.sv - self-checking bench for direction_square_pipe
module tb_direction_square_pipe;
   localparam int W      = 32;
   localparam int Q      = 16;
   localparam int STAGES = 2;
   localparam int TW     = 8;

   typedef struct packed {
      logic [31:0] x, y, z, sx, sy, sz;
      logic [33:0] len;
      logic [2:0]  ovf;
      logic [7:0]  tag;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   direction_square_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

   direction_square_pipe #(.WIDTH(W), .Q_BITS(Q), .STAGES(STAGES), .TAG_W(TW)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int   n_cmp = 0;
   int   n_bad = 0;
   int   n_out = 0;
   obs_t exp_q[$];
   obs_t last_obs, held;
   logic stall_prev = 1'b0;
   logic saw_out, in_fired, last_in_ready;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic void sq_ref(input logic [31:0] c, input logic sat,
                                  output logic [31:0] s, output logic o);
      longint v, p;
      v = longint'($signed(c));
      p = v * v;
      o = (p >= (longint'(1) << 47));
      s = (o && sat) ? 32'h7FFF_FFFF : 32'(p >>> 16);
   endfunction

   function automatic obs_t model(input logic [31:0] x, y, z, input logic sat, input logic [7:0] tag);
      obs_t e;
      e.x = x; e.y = y; e.z = z; e.tag = tag;
      sq_ref(x, sat, e.sx, e.ovf[0]);
      sq_ref(y, sat, e.sy, e.ovf[1]);
      sq_ref(z, sat, e.sz, e.ovf[2]);
      e.len = 34'(e.sx) + 34'(e.sy) + 34'(e.sz);
      return e;
   endfunction

   function automatic obs_t get_obs();
      obs_t o;
      o.x = bus.out_x; o.y = bus.out_y; o.z = bus.out_z;
      o.sx = bus.out_sqr_x; o.sy = bus.out_sqr_y; o.sz = bus.out_sqr_z;
      o.len = bus.out_len_sqr; o.ovf = bus.out_ovf; o.tag = bus.out_tag;
      return o;
   endfunction

   function automatic logic [31:0] pick();
      logic [31:0] r;
      r = $urandom;
      case ($urandom % 8)
         0: return 32'h8000_0000;
         1: return 32'h7FFF_FFFF;
         2: return 32'h00B5_04F3;
         3: return 32'h00B5_04F4;
         4: return 32'hFF4A_FB0D;
         5: return {{8{r[23]}}, r[23:0]};
         default: return r;
      endcase
   endfunction

   task automatic set_beat(input logic [31:0] x, y, z, input logic s, input logic [7:0] t);
      bus.in_x = x; bus.in_y = y; bus.in_z = z; bus.in_sat_en = s; bus.in_tag = t;
   endtask

   // One cycle: sample #1 after the falling edge, score, then step to the next falling edge.
   task automatic tick();
      obs_t o;
      #1;
      saw_out = 1'b0;
      in_fired = 1'b0;
      if (rst_n) begin
         o = get_obs();
         last_obs = o;
         last_in_ready = bus.in_ready;
         if (stall_prev) chk("stall_hold", 256'(o), 256'(held));
         if (bus.out_valid) begin
            saw_out = 1'b1;
            if (exp_q.size() == 0) chk("spurious_out_valid", 256'(bus.out_valid), 256'(0));
            else begin
               chk("beat", 256'(o), 256'(exp_q[0]));
               if (bus.out_ready) begin
                  void'(exp_q.pop_front());
                  n_out++;
               end
            end
         end else begin
            chk("idle_mask", 256'(o), 256'(0));
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         held = o;
         if (bus.in_valid && bus.in_ready) begin
            in_fired = 1'b1;
            exp_q.push_back(model(bus.in_x, bus.in_y, bus.in_z, bus.in_sat_en, bus.in_tag));
         end
      end
      @(negedge clk);
   endtask

   task automatic run_single(input string nm);
      int lat;
      bus.in_valid = 1'b1;
      tick();
      chk({nm, "_accept"}, 256'(in_fired), 256'(1));
      bus.in_valid = 1'b0;
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!saw_out && lat < 12);
      chk({nm, "_latency"}, 256'(lat), 256'(STAGES));
   endtask

   initial begin
      int k, sent, out_start, first, cnt, gap;
      logic saw_low;
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      set_beat(0, 0, 0, 1'b0, 8'h00);
      repeat (2) @(negedge clk);
      #1;
      chk("reset_out_valid", 256'(bus.out_valid), 256'(0));
      chk("reset_data", 256'(get_obs()), 256'(0));
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      tick();
      chk("ready_after_reset", 256'(last_in_ready), 256'(1));

      set_beat(32'h0001_0000, 32'h0002_0000, 32'hFFFD_0000, 1'b1, 8'hA5);
      run_single("basic");
      chk("basic_sqr_x", 256'(last_obs.sx), 256'(32'h0001_0000));
      chk("basic_sqr_y", 256'(last_obs.sy), 256'(32'h0004_0000));
      chk("basic_sqr_z", 256'(last_obs.sz), 256'(32'h0009_0000));
      chk("basic_len", 256'(last_obs.len), 256'(34'h0_000E_0000));
      chk("basic_ovf", 256'(last_obs.ovf), 256'(3'b000));
      chk("basic_tag", 256'(last_obs.tag), 256'(8'hA5));

      set_beat(32'h0100_0000, 0, 0, 1'b1, 8'h11);
      run_single("ovf_sat");
      chk("ovf_sat_sqr_x", 256'(last_obs.sx), 256'(32'h7FFF_FFFF));
      chk("ovf_sat_flag", 256'(last_obs.ovf), 256'(3'b001));
      chk("ovf_sat_len", 256'(last_obs.len), 256'(34'h0_7FFF_FFFF));
      set_beat(32'h0100_0000, 0, 0, 1'b0, 8'h12);
      run_single("ovf_wrap");
      chk("ovf_wrap_sqr_x", 256'(last_obs.sx), 256'(32'h0000_0000));
      chk("ovf_wrap_flag", 256'(last_obs.ovf), 256'(3'b001));

      // Backpressure: out_ready 1,0,0 repeating against 8 back-to-back beats.
      k = 0; sent = 0; saw_low = 1'b0; out_start = n_out;
      set_beat(pick(), pick(), pick(), 1'($urandom), 8'd0);
      while ((n_out - out_start) < 8 && k < 200) begin
         bus.out_ready = (k % 3 == 0);
         bus.in_valid = (sent < 8);
         tick();
         if (bus.in_valid && !last_in_ready) saw_low = 1'b1;
         if (in_fired) begin
            sent++;
            set_beat(pick(), pick(), pick(), 1'($urandom), 8'(sent));
         end
         k++;
      end
      bus.in_valid = 1'b0;
      chk("bp_out_count", 256'(n_out - out_start), 256'(8));
      chk("bp_in_ready_low_seen", 256'(saw_low), 256'(1));

      // Throughput: 16 beats with out_ready held high.
      bus.out_ready = 1'b1;
      sent = 0; first = -1; cnt = 0; gap = 0;
      for (int j = 0; j < 24; j++) begin
         bus.in_valid = (sent < 16);
         set_beat(pick(), pick(), pick(), 1'($urandom), 8'($urandom));
         tick();
         if (j < 16) chk("tp_in_ready", 256'(last_in_ready), 256'(1));
         if (in_fired) sent++;
         if (saw_out) begin
            if (first < 0) first = j;
            if (j != first + cnt) gap++;
            cnt++;
         end
      end
      bus.in_valid = 1'b0;
      chk("tp_first_out", 256'(first), 256'(STAGES));
      chk("tp_out_count", 256'(cnt), 256'(16));
      chk("tp_gaps", 256'(gap), 256'(0));

      // Random traffic against the model.
      for (int j = 0; j < 300; j++) begin
         if (!bus.in_valid || in_fired) begin
            set_beat(pick(), pick(), pick(), 1'($urandom), 8'($urandom));
            bus.in_valid = ($urandom % 4 != 0);
         end
         bus.out_ready = ($urandom % 3 != 0);
         tick();
      end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      k = 0;
      while (exp_q.size() > 0 && k < 20) begin
         tick();
         k++;
      end
      chk("drain_empty", 256'(exp_q.size()), 256'(0));

      // Reset with two beats in flight.
      bus.out_ready = 1'b0;
      set_beat(32'h0003_0000, 32'h0001_0000, 0, 1'b1, 8'h21);
      bus.in_valid = 1'b1;
      tick();
      set_beat(32'h0004_0000, 0, 32'h0001_0000, 1'b1, 8'h22);
      tick();
      bus.in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_async_valid", 256'(bus.out_valid), 256'(0));
      chk("rst_async_data", 256'(get_obs()), 256'(0));
      exp_q.delete();
      stall_prev = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      bus.out_ready = 1'b1;
      repeat (3) begin
         tick();
         chk("post_reset_no_beat", 256'(saw_out), 256'(0));
      end
      set_beat(32'h0001_0000, 32'h0002_0000, 32'hFFFD_0000, 1'b0, 8'h5A);
      run_single("after_reset");
      chk("after_reset_len", 256'(last_obs.len), 256'(34'h0_000E_0000));
      chk("after_reset_tag", 256'(last_obs.tag), 256'(8'h5A));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
